pack64_arbiter: RTL

Shares one 32-to-64-bit word-pair packer between up to eight 32-bit producers, such as integral-image and window-fetch channels, feeding the 64-bit memory write port in the face-detection pipeline. The block arbitrates round-robin and locks the grant for a whole number of word pairs, so halves from different sources never interleave. Each packed 64-bit word is tagged with its source ID.

---
 rtl/pack64_arb_pkg.sv | 36 +++
 rtl/pack64_arbiter_packer.sv | 41 ++++
 rtl/pack64_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/pack64_arb_pkg.sv
// Shared constants, FSM state type and round-robin selection for pack64_arbiter.
package pack64_arb_pkg;

  localparam int unsigned DATA_IN_W  = 32;
  localparam int unsigned DATA_OUT_W = 64;
  localparam int unsigned MAX_SRC    = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

  // Round-robin winner: scan from ptr+1 (mod num_src) upward and return the
  // first requesting index. Returns 0 when nothing requests.
  function automatic int unsigned rr_winner(
    input logic [MAX_SRC-1:0] req,
    input int unsigned        ptr,
    input int unsigned        num_src
  );
    int unsigned win;
    int unsigned idx;
    logic        found;
    win   = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      idx = (ptr + k) % num_src;
      if (!found && (k <= num_src) && req[idx[2:0]]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/pack64_arbiter_packer.sv
// word_pair_packer: captures the low half of a pair, then assembles the 64-bit
// word with its source tag and raises a one-cycle ready pulse.
module word_pair_packer
  import pack64_arb_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_low,
  input  logic                  load_high,
  input  logic [ID_W-1:0]       id,
  input  logic [DATA_IN_W-1:0]  word,
  output logic [DATA_OUT_W-1:0] data_out,
  output logic [ID_W-1:0]       src_id,
  output logic                  output_ready
);

  logic [DATA_IN_W-1:0] low_q;

  // The high half is written straight into the output register together with
  // the held low half, so the output word only changes on a completed pair.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      low_q        <= '0;
      data_out     <= '0;
      src_id       <= '0;
      output_ready <= 1'b0;
    end else begin
      output_ready <= load_high;
      if (load_low) begin
        low_q <= word;
      end
      if (load_high) begin
        data_out <= {word, low_q};
        src_id   <= id;
      end
    end
  end

endmodule

// File: rtl/pack64_arbiter.sv
// pack64_arbiter: round-robin shares one 32->64 bit word-pair packer among
// NUM_SRC producers, locking the grant for PAIRS_PER_GRANT packed words.
// Optional build macro PACK64_ARB_SRC0_PRIO_EN gives source 0 absolute
// priority at arbitration time.
module pack64_arbiter
  import pack64_arb_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int PAIRS_PER_GRANT = 1,
  parameter int ID_W            = $clog2(NUM_SRC)
) (
  input  logic                           iClk,
  input  logic                           iReset_n,
  input  logic [NUM_SRC-1:0]             iReq,
  input  logic [NUM_SRC*DATA_IN_W-1:0]   iData,
  input  logic                           iStall,
  output logic [NUM_SRC-1:0]             oAck,
  output logic                           oOutput_ready,
  output logic [DATA_OUT_W-1:0]          oData_out,
  output logic [ID_W-1:0]                oSrc_id,
  output logic                           oBusy
);

  localparam int CNT_W = $clog2(PAIRS_PER_GRANT + 1);

  state_t               state;
  logic [ID_W-1:0]      owner;
  logic [ID_W-1:0]      ptr;
  logic [CNT_W-1:0]     cnt;
  logic [ID_W-1:0]      winner;
  logic [MAX_SRC-1:0]   req_ext;
  logic [NUM_SRC-1:0]   ack;
  logic                 xfer;
  logic                 load_low;
  logic                 load_high;
  logic [DATA_IN_W-1:0] word;

  // Arbitration candidate for the IDLE state.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_SRC-1:0]   = iReq;
    winner = ID_W'(rr_winner(req_ext, 32'(ptr), NUM_SRC));
`ifdef PACK64_ARB_SRC0_PRIO_EN
    if (iReq[0]) begin
      winner = '0;
    end
`endif
  end

  // Only the current owner can be acknowledged, and only outside IDLE.
  always_comb begin
    ack = '0;
    if (((state == LOW) || (state == HIGH)) && !iStall) begin
      ack[owner] = iReq[owner];
    end
  end

  assign oAck      = ack;
  assign xfer      = |ack;
  assign load_low  = xfer && (state == LOW);
  assign load_high = xfer && (state == HIGH);
  assign word      = iData[32'(owner)*DATA_IN_W +: DATA_IN_W];
  assign oBusy     = (state != IDLE);

  // Grant FSM: arbitrate, then collect PAIRS_PER_GRANT low/high pairs.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state <= IDLE;
      owner <= '0;
      cnt   <= '0;
      ptr   <= ID_W'(NUM_SRC - 1);
    end else if (!iStall) begin
      unique case (state)
        IDLE: begin
          if (|iReq) begin
            owner <= winner;
            cnt   <= CNT_W'(PAIRS_PER_GRANT);
            state <= LOW;
          end
        end
        LOW: begin
          if (xfer) begin
            state <= HIGH;
          end
        end
        HIGH: begin
          if (xfer) begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end
            // cnt is tested before its decrement takes effect
            if (cnt > CNT_W'(1)) begin
              state <= LOW;
            end else begin
              state <= IDLE;
              ptr   <= owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  word_pair_packer #(
    .ID_W(ID_W)
  ) u_packer (
    .clk          (iClk),
    .reset_n      (iReset_n),
    .load_low     (load_low),
    .load_high    (load_high),
    .id           (owner),
    .word         (word),
    .data_out     (oData_out),
    .src_id       (oSrc_id),
    .output_ready (oOutput_ready)
  );

endmodule
